// File: rtl/cpu_hazard_ctrl.sv
// Register scoreboard and decode interlock for the moxie pipeline.
// Optional same-cycle writeback forwarding is enabled by defining HAZARD_BYPASS_EN.
module cpu_hazard_ctrl #(
    parameter int NREGS = 16,
    parameter int CNT_W = 2,
    parameter int TOT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             issue_valid_i,
    input  logic             rd_a_en_i,
    input  logic [3:0]       rd_a_idx_i,
    input  logic             rd_b_en_i,
    input  logic [3:0]       rd_b_idx_i,
    input  logic             wr_en_i,
    input  logic [3:0]       wr_idx_i,
    input  logic             retire_valid_i,
    input  logic [3:0]       retire_idx_i,
    output logic             stall_o,
    output logic [NREGS-1:0] pending_o,
    output logic [TOT_W-1:0] pending_count_o,
    output logic             underflow_o
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [TOT_W-1:0] TOT_ONE  = {{(TOT_W-1){1'b0}}, 1'b1};
    localparam logic [TOT_W-1:0] TOT_ZERO = {TOT_W{1'b0}};

    logic [CNT_W-1:0] cnt_r     [NREGS];
    logic [CNT_W-1:0] cnt_nxt_s [NREGS];
    logic [NREGS-1:0] pending_r;
    logic [NREGS-1:0] pending_nxt_s;
    logic [TOT_W-1:0] total_r;
    logic [TOT_W-1:0] total_nxt_s;
    logic             underflow_r;

    logic haz_a_s;
    logic haz_b_s;
    logic sat_s;
    logic stall_s;
    logic wr_acc_s;
    logic same_idx_s;
    logic underflow_set_s;
    logic ret_ok_s;
    logic byp_a_s;
    logic byp_b_s;

    // Same-cycle writeback forwarding: the last outstanding write to a register lands now
    always_comb begin
`ifdef HAZARD_BYPASS_EN
        byp_a_s = retire_valid_i && (retire_idx_i == rd_a_idx_i) && (cnt_r[rd_a_idx_i] == CNT_ONE);
        byp_b_s = retire_valid_i && (retire_idx_i == rd_b_idx_i) && (cnt_r[rd_b_idx_i] == CNT_ONE);
`else
        byp_a_s = 1'b0;
        byp_b_s = 1'b0;
`endif
    end

    // Hazard detection, stall and issue acceptance
    always_comb begin
        haz_a_s    = rd_a_en_i && (cnt_r[rd_a_idx_i] != CNT_ZERO) && !byp_a_s;
        haz_b_s    = rd_b_en_i && (cnt_r[rd_b_idx_i] != CNT_ZERO) && !byp_b_s;
        sat_s      = wr_en_i && (cnt_r[wr_idx_i] == CNT_MAX);
        stall_s    = issue_valid_i && (haz_a_s || haz_b_s || sat_s) && !flush_i;
        wr_acc_s   = issue_valid_i && !stall_s && !flush_i && wr_en_i;
        same_idx_s = wr_acc_s && (wr_idx_i == retire_idx_i);
        // An accept to the same register covers a retire even at counter zero
        underflow_set_s = !flush_i && retire_valid_i && !same_idx_s
                          && (cnt_r[retire_idx_i] == CNT_ZERO);
        ret_ok_s   = !flush_i && retire_valid_i && !underflow_set_s;
    end

    // Per-register counter and pending-bit next state
    always_comb begin
        for (int n = 0; n < NREGS; n++) begin
            cnt_nxt_s[n] = cnt_r[n];
            if (flush_i) begin
                cnt_nxt_s[n] = CNT_ZERO;
            end else if (wr_acc_s && (wr_idx_i == 4'(n))
                         && !(retire_valid_i && (retire_idx_i == 4'(n)))) begin
                cnt_nxt_s[n] = cnt_r[n] + CNT_ONE;
            end else if (retire_valid_i && (retire_idx_i == 4'(n))
                         && !(wr_acc_s && (wr_idx_i == 4'(n)))
                         && (cnt_r[n] != CNT_ZERO)) begin
                cnt_nxt_s[n] = cnt_r[n] - CNT_ONE;
            end else begin
                cnt_nxt_s[n] = cnt_r[n];
            end
            pending_nxt_s[n] = (cnt_nxt_s[n] != CNT_ZERO);
        end
    end

    // Total outstanding-write count next state
    always_comb begin
        total_nxt_s = total_r;
        if (flush_i) begin
            total_nxt_s = TOT_ZERO;
        end else begin
            total_nxt_s = total_r + (wr_acc_s ? TOT_ONE : TOT_ZERO)
                                  - (ret_ok_s ? TOT_ONE : TOT_ZERO);
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int n = 0; n < NREGS; n++) begin
                cnt_r[n] <= CNT_ZERO;
            end
            pending_r   <= {NREGS{1'b0}};
            total_r     <= TOT_ZERO;
            underflow_r <= 1'b0;
        end else begin
            for (int n = 0; n < NREGS; n++) begin
                cnt_r[n] <= cnt_nxt_s[n];
            end
            pending_r   <= pending_nxt_s;
            total_r     <= total_nxt_s;
            underflow_r <= underflow_r || underflow_set_s;
        end
    end

    assign stall_o         = stall_s;
    assign pending_o       = pending_r;
    assign pending_count_o = total_r;
    assign underflow_o     = underflow_r;

endmodule

// File: doc/cpu_hazard_ctrl.md
Name: cpu_hazard_ctrl

Overview:
- Register scoreboard and pipeline interlock controller between the decode stage and the writeback stage of the moxie pipeline.
- Tracks outstanding register writes issued by decode that have not yet retired at writeback.
- Raises the decode stall line whenever a decoded instruction reads a register with a pending write, or would overflow a tracking counter.
- Also provides a flush path and a sticky retire-underflow error.

Parameters:
- NREGS, 16, number of architectural registers tracked (index width 4).
- CNT_W, 2, width of each per-register pending-write counter (max outstanding = 2^CNT_W-1 = 3).
- TOT_W, 6, width of total outstanding-write count output.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- flush_i  in  1  pipeline flush; clears all pending state next edge.
- issue_valid_i  in  1  decode presents a decoded instruction this cycle.
- rd_a_en_i  in  1  instruction reads regA.
- rd_a_idx_i  in  4  regA index.
- rd_b_en_i  in  1  instruction reads regB.
- rd_b_idx_i  in  4  regB index.
- wr_en_i  in  1  instruction writes a register.
- wr_idx_i  in  4  destination index.
- retire_valid_i  in  1  writeback completes a register write this cycle.
- retire_idx_i  in  4  register written back.
- stall_o  out  1  decode must hold; combinational.
- pending_o  out  16  bit n = 1 when counter[n] != 0; registered.
- pending_count_o  out  TOT_W  total outstanding writes; registered.
- underflow_o  out  1  sticky error; retire to a register with counter 0.

Behaviour:
- Reset (rst_i low, asynchronous): all counters = 0, pending_o = 0, pending_count_o = 0, underflow_o = 0. stall_o = 0 while in reset.
- Hazard terms, all combinational from current state and inputs:
  - hazA = rd_a_en_i && counter[rd_a_idx_i] != 0.
  - hazB = rd_b_en_i && counter[rd_b_idx_i] != 0.
  - sat = wr_en_i && counter[wr_idx_i] == max.
- stall_o = issue_valid_i && (hazA || hazB || sat) && !flush_i.
- Issue accepted = issue_valid_i && !stall_o && !flush_i. On accept with wr_en_i: counter[wr_idx_i] += 1 at the next edge.
- Retire (retire_valid_i): counter[retire_idx_i] -= 1 at the next edge.
  - If that counter is 0 (and it is not incremented by the same-cycle accept): it stays 0 and underflow_o is set.
- Simultaneous accept-write and retire on the same index: net counter unchanged, no underflow, even when the counter is 0.
- Simultaneous accept and retire on different indices: both updates apply.
- pending_count_o tracks the sum of all counters: +1 on accepted write, -1 on valid non-underflow retire, net 0 when both occur.
- flush_i: at the next edge all counters and pending_count_o = 0. A retire or issue in the same cycle is ignored. underflow_o is unaffected.
- underflow_o clears only on reset.
- Self-dependent instruction (reads and writes the same register): stalls only on the existing pending state; its own write is not counted until accepted.
- No latency beyond one edge: an accepted write makes a dependent next-cycle read stall.

Optional Feature:
- Macro HAZARD_BYPASS_EN.
- Defined: a read hazard is suppressed when retire_valid_i && retire_idx_i == read index && counter == 1, i.e. same-cycle writeback forwarding.
- Not defined: no bypass; such reads stall for one extra cycle until the counter reaches 0.

Test Plan:
- Reset-then-idle: release rst_i with no activity -> stall_o=0, pending_o=0x0000, pending_count_o=0, underflow_o=0.
- RAW: issue wr_en r3, next cycle issue rd_a r3 -> stall_o=1 until retire r3; counter returns to 0, then accept, pending_count_o back to 0.
- Saturation: three accepted writes to r5, fourth write to r5 -> stall_o=1, pending_count_o=3; one retire of r5 -> fourth accepted next cycle.
- Same-cycle accept+retire r7 with counter=1 -> counter stays 1, pending_o[7]=1, pending_count_o unchanged.
- Underflow: retire r9 with counter 0 -> underflow_o=1 and it stays 1 through flush; clears only after rst_i low.
- Flush/bypass: pending r2 and r4, flush_i -> pending_o=0 next cycle. With HAZARD_BYPASS_EN, read r2 with counter 1 and same-cycle retire r2 -> stall_o=0; without the macro -> stall_o=1.
